// File: rtl/gate_vector_checker_if.sv
// rtl/gate_vector_checker_if.sv - stimulus/check bundle between the vector checker and the gate under check
interface gate_vector_checker_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);
  logic             start;
  logic             y;
  logic [N_IN-1:0]  a;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [N_IN-1:0]  fail_vec;

  modport master (
    input  start, y,
    output a, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, y,
    input  a, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - exhaustive input sweep of a logic gate checked against a truth table
module gate_vector_checker #(
  parameter int                 N_IN        = 2,
  parameter logic [2**N_IN-1:0] TRUTH       = 4'b1000,
  parameter int                 STEP_CYCLES = 4,
  parameter int                 ERR_W       = 8
) (
  input logic                    clk,
  input logic                    rst,
  gate_vector_checker_if.master  bus
);

  localparam int                CNT_W     = $clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(STEP_CYCLES - 2);
  localparam logic [N_IN-1:0]   LAST_VEC  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             r_state, w_state;
  logic [N_IN-1:0]    r_a, w_a;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_pass, w_pass;
  logic [ERR_W-1:0]   r_err, w_err;
  logic [N_IN-1:0]    r_fail_vec, w_fail_vec;
  logic               w_mismatch;

  always_comb begin
    w_state    = r_state;
    w_a        = r_a;
    w_cnt      = r_cnt;
    w_busy     = r_busy;
    w_done     = r_done;
    w_pass     = r_pass;
    w_err      = r_err;
    w_fail_vec = r_fail_vec;
    w_mismatch = (bus.y != TRUTH[r_a]);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state    = S_HOLD;
          w_a        = '0;
          w_cnt      = '0;
          w_err      = '0;
          w_fail_vec = '0;
          w_done     = 1'b0;
          w_pass     = 1'b0;
          w_busy     = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state = S_SAMPLE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        // A zero count means no earlier mismatch this sweep, even with saturation.
        if (w_mismatch) begin
          if (r_err == '0) begin
            w_fail_vec = r_a;
          end
          if (r_err != '1) begin
            w_err = r_err + ERR_W'(1);
          end
        end
        if (r_a == LAST_VEC) begin
          w_state = S_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_pass  = (r_err == '0) && !w_mismatch;
        end else begin
          w_state = S_HOLD;
          w_a     = r_a + N_IN'(1);
          w_cnt   = '0;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_fail_vec <= '0;
    end else begin
      r_state    <= w_state;
      r_a        <= w_a;
      r_cnt      <= w_cnt;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_pass     <= w_pass;
      r_err      <= w_err;
      r_fail_vec <= w_fail_vec;
    end
  end

  assign bus.a         = r_a;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.fail_vec  = r_fail_vec;

endmodule
